host_frame_link: RTL and testbench
==================================

HOST_FRAME_LINK -- requirements
Module: host_frame_link

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the maximum idle gap in masterClock cycles between bytes of one receive frame.
REQ-002 SHALL have port masterClock, input, 1, the single operating clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port rxValid, input, 1, a one-cycle strobe from the UART receiver marking rxByte valid.
REQ-005 SHALL have port rxByte, input, 8, the received byte.
REQ-006 SHALL have port dataReceived, output, 1, meaning a complete frame is held for the sandbox process.
REQ-007 SHALL have port control, output, 8, the frame control byte.
REQ-008 SHALL have port inputData, output, 32, the frame data word.
REQ-009 SHALL have port clearDR, input, 1, the sandbox acknowledge that releases the held frame.
REQ-010 SHALL have port transmitData, input, 1, the sandbox transmit request; a rising edge starts a transmit.
REQ-011 SHALL have port status, input, 8, the status byte to send.
REQ-012 SHALL have port outputData, input, 32, the data word to send.
REQ-013 SHALL have port txValid, output, 1, meaning txByte is offered to the UART transmitter.
REQ-014 SHALL have port txByte, output, 8, the byte to transmit.
REQ-015 SHALL have port txReady, input, 1, meaning the UART transmitter accepts a byte; a byte transfers on any cycle with txValid=1 and txReady=1.
REQ-016 SHALL have port rxOverrun, output, 1, a sticky flag: a byte arrived while a frame was held.
REQ-017 SHALL have port rxTimeout, output, 1, a sticky flag: a partial frame was discarded on timeout.

Function
REQ-018 The receive frame SHALL be 5 bytes: control first, then inputData MSB first (bits 31:24, 23:16, 15:8, 7:0).
REQ-019 The receive FSM SHALL have states R_IDLE, R_DATA (byte index 0..3), R_PEND and R_HOLD.
REQ-020 R_IDLE + rxValid: store the control byte, go to R_DATA with index 0, zero the gap counter.
REQ-021 R_DATA + rxValid: store the byte in its lane, increment the index, zero the gap counter.
REQ-022 On the 4th data byte in R_DATA, the FSM SHALL go to R_HOLD if clearDR=0, else to R_PEND.
REQ-023 R_PEND SHALL go to R_HOLD on the first cycle with clearDR=0.
REQ-024 dataReceived SHALL equal 1 exactly while in R_HOLD; with clearDR=0, it rises the cycle after the last byte strobe.
REQ-025 control and inputData SHALL be stable whenever dataReceived=1 and SHALL change only as new bytes are stored.
REQ-026 R_HOLD + clearDR=1: dataReceived SHALL drop the next cycle and the FSM SHALL return to R_IDLE.
REQ-027 Bytes strobed in R_PEND or R_HOLD SHALL be discarded and SHALL set rxOverrun.
REQ-028 In R_DATA, the gap counter SHALL increment on each cycle without rxValid.
REQ-029 When the gap counter reaches TIMEOUT_CYCLES-1 without rxValid, the partial frame SHALL be discarded, the FSM SHALL go to R_IDLE, and rxTimeout SHALL be set.
REQ-030 If rxValid coincides with the timeout cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-031 The gap counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits; it SHALL not wrap.
REQ-032 Transmit edge detect: the previous value of transmitData SHALL be registered; an edge is transmitData=1 while the previous value is 0.
REQ-033 The transmit FSM SHALL have states T_IDLE and T_SEND (byte index 0..4).
REQ-034 T_IDLE + edge: latch status and outputData, go to T_SEND index 0; txValid SHALL be 1 the next cycle.
REQ-035 Transmit byte order SHALL be status, then outputData MSB first.
REQ-036 txByte SHALL be held constant while txValid=1 and txReady=0.
REQ-037 On each transfer the index SHALL advance; after the 5th transfer, txValid SHALL drop the next cycle and the FSM SHALL return to T_IDLE.
REQ-038 Edges occurring in T_SEND SHALL be ignored; the latched data SHALL be unaffected by input changes during T_SEND.
REQ-039 The receive and transmit paths SHALL be fully independent and SHALL run concurrently.

Reset
REQ-040 On reset=1 at a clock edge: R_IDLE and T_IDLE, counters 0, dataReceived=0, control=0, inputData=0, txValid=0, txByte=0, rxOverrun=0, rxTimeout=0.
REQ-041 On reset, the previous-transmitData register SHALL be set to 1, so that transmitData already high at reset release is not an edge.
REQ-042 Reset mid-frame SHALL discard partial receive and transmit frames without emitting further bytes.

Verification
REQ-043 Bytes 01,DE,AD,BE,EF with clearDR=0 -> dataReceived=1 the cycle after EF, control=01, inputData=DEADBEEF; clearDR=1 -> dataReceived=0 the next cycle.
REQ-044 Frame completes while clearDR=1 -> dataReceived stays 0; clearDR falls -> dataReceived=1 the next cycle.
REQ-045 Held frame plus extra byte 55 -> rxOverrun=1 and inputData unchanged.
REQ-046 TIMEOUT_CYCLES=8; 3 bytes, then silence -> rxTimeout=1, FSM in R_IDLE; a following 5-byte frame is received correctly.
REQ-047 status=A5, outputData=12345678, transmitData rises, txReady toggling 1/0 -> bytes A5,12,34,56,78 in order, each held while txReady=0, txValid=0 after 78.
REQ-048 Second transmitData edge mid-send -> exactly 5 bytes sent; reset asserted mid-send -> txValid=0 the next cycle.

Source files
------------

// File: rtl/host_frame_link.sv
`default_nettype none
// ============================================================================
// Module   : host_frame_link
// Purpose  : Byte-framed host link. Assembles 5-byte receive frames
//            (control + 32-bit data, MSB first) for a sandbox process and
//            serialises 5-byte transmit frames (status + 32-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module host_frame_link #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        masterClock,
    input  logic        reset,
    // receive side
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    input  logic        clearDR,
    // transmit side
    input  logic        transmitData,
    input  logic [7:0]  status,
    input  logic [31:0] outputData,
    output logic        txValid,
    output logic [7:0]  txByte,
    input  logic        txReady,
    // sticky error flags
    output logic        rxOverrun,
    output logic        rxTimeout
);

    // Gap counter is one bit wider than needed so it can never wrap.
    localparam int              GAP_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_PEND = 2'd2,
        R_HOLD = 2'd3
    } rx_state_t;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------------
    // Receive path registers
    // ------------------------------------------------------------------------
    rx_state_t          rx_state_q;
    logic [1:0]         rx_idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic               dataReceived_q;
    logic [7:0]         control_q;
    logic [31:0]        inputData_q;
    logic               rxOverrun_q;
    logic               rxTimeout_q;

    // ------------------------------------------------------------------------
    // Transmit path registers
    // ------------------------------------------------------------------------
    tx_state_t          tx_state_q;
    logic [2:0]         tx_idx_q;
    logic [31:0]        tx_buf_q;      // bytes still to send after txByte_q
    logic               txValid_q;
    logic [7:0]         txByte_q;
    logic               tx_prev_q;     // previous transmitData for edge detect

    logic               tx_edge;
    logic               tx_xfer;

    assign tx_edge = transmitData & ~tx_prev_q;
    assign tx_xfer = txValid_q & txReady;

    // Receive FSM: frame assembly, hand-off to the sandbox, overrun and timeout.
    always_ff @(posedge masterClock) begin
        if (reset) begin
            rx_state_q     <= R_IDLE;
            rx_idx_q       <= 2'd0;
            gap_q          <= '0;
            dataReceived_q <= 1'b0;
            control_q      <= 8'h00;
            inputData_q    <= 32'h0;
            rxOverrun_q    <= 1'b0;
            rxTimeout_q    <= 1'b0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (rxValid) begin
                        control_q  <= rxByte;
                        rx_idx_q   <= 2'd0;
                        gap_q      <= '0;
                        rx_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rxValid) begin
                        // A byte on the timeout cycle still wins.
                        case (rx_idx_q)
                            2'd0:    inputData_q[31:24] <= rxByte;
                            2'd1:    inputData_q[23:16] <= rxByte;
                            2'd2:    inputData_q[15:8]  <= rxByte;
                            default: inputData_q[7:0]   <= rxByte;
                        endcase
                        gap_q <= '0;
                        if (rx_idx_q == 2'd3) begin
                            rx_idx_q <= 2'd0;
                            if (clearDR) begin
                                // Sandbox still acknowledging the previous frame.
                                rx_state_q <= R_PEND;
                            end else begin
                                rx_state_q     <= R_HOLD;
                                dataReceived_q <= 1'b1;
                            end
                        end else begin
                            rx_idx_q <= rx_idx_q + 2'd1;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        // Abandon the partial frame; held bytes stay visible
                        // but dataReceived never asserts for them.
                        gap_q       <= '0;
                        rx_idx_q    <= 2'd0;
                        rxTimeout_q <= 1'b1;
                        rx_state_q  <= R_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_ONE;
                    end
                end
                R_PEND: begin
                    if (rxValid) begin
                        rxOverrun_q <= 1'b1;
                    end
                    if (!clearDR) begin
                        rx_state_q     <= R_HOLD;
                        dataReceived_q <= 1'b1;
                    end
                end
                R_HOLD: begin
                    if (rxValid) begin
                        rxOverrun_q <= 1'b1;
                    end
                    if (clearDR) begin
                        rx_state_q     <= R_IDLE;
                        dataReceived_q <= 1'b0;
                    end
                end
                default: begin
                    rx_state_q     <= R_IDLE;
                    dataReceived_q <= 1'b0;
                end
            endcase
        end
    end

    // Transmit FSM: edge-triggered capture of status/data, then a 5-byte
    // valid/ready handshake with txByte held until each transfer.
    always_ff @(posedge masterClock) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            tx_idx_q   <= 3'd0;
            tx_buf_q   <= 32'h0;
            txValid_q  <= 1'b0;
            txByte_q   <= 8'h00;
            // Treat a level already high at reset release as old news.
            tx_prev_q  <= 1'b1;
        end else begin
            tx_prev_q <= transmitData;
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_edge) begin
                        txByte_q   <= status;
                        tx_buf_q   <= outputData;
                        txValid_q  <= 1'b1;
                        tx_idx_q   <= 3'd0;
                        tx_state_q <= T_SEND;
                    end
                end
                T_SEND: begin
                    // Edges while sending are deliberately ignored.
                    if (tx_xfer) begin
                        if (tx_idx_q == 3'd4) begin
                            txValid_q  <= 1'b0;
                            tx_idx_q   <= 3'd0;
                            tx_state_q <= T_IDLE;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            txByte_q <= tx_buf_q[31:24];
                            tx_buf_q <= {tx_buf_q[23:0], 8'h00};
                        end
                    end
                end
                default: begin
                    txValid_q  <= 1'b0;
                    tx_state_q <= T_IDLE;
                end
            endcase
        end
    end

    assign dataReceived = dataReceived_q;
    assign control      = control_q;
    assign inputData    = inputData_q;
    assign rxOverrun    = rxOverrun_q;
    assign rxTimeout    = rxTimeout_q;
    assign txValid      = txValid_q;
    assign txByte       = txByte_q;

endmodule
`default_nettype wire

// File: tb/tb_host_frame_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_frame_link
// Purpose  : Self-checking bench for host_frame_link: table-driven receive
//            frames plus hand-written timeout, overrun and transmit sequences,
//            with queue scoreboards for both directions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_frame_link;

    localparam int TO = 8;

    logic        masterClock = 1'b0;
    logic        reset       = 1'b1;
    logic        rxValid     = 1'b0;
    logic [7:0]  rxByte      = 8'h00;
    logic        clearDR     = 1'b0;
    logic        transmitData = 1'b1;
    logic [7:0]  status      = 8'h00;
    logic [31:0] outputData  = 32'h0;
    logic        txReady     = 1'b1;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        txValid;
    logic [7:0]  txByte;
    logic        rxOverrun;
    logic        rxTimeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  tx_q[$];   // expected transmit bytes
    logic [39:0] rx_q[$];   // expected {control, inputData} frames

    int rdy_mode = 0;       // 0: txReady always 1, 1: toggling

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] data;
        bit          clr_early;  // clearDR high while the frame completes
        bit          extra;      // send a stray byte while frame is held/pending
    } rx_vec_t;

    rx_vec_t vecs[4];

    host_frame_link #(.TIMEOUT_CYCLES(TO)) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .rxValid      (rxValid),
        .rxByte       (rxByte),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .clearDR      (clearDR),
        .transmitData (transmitData),
        .status       (status),
        .outputData   (outputData),
        .txValid      (txValid),
        .txByte       (txByte),
        .txReady      (txReady),
        .rxOverrun    (rxOverrun),
        .rxTimeout    (rxTimeout)
    );

    always #5 masterClock = ~masterClock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // txReady driver
    always @(posedge masterClock) begin
        #1;
        if (rdy_mode == 1) txReady = ~txReady;
        else               txReady = 1'b1;
    end

    // Transmit monitor: compares each transferred byte against the scoreboard
    // and checks txByte stays put across stalled cycles.
    logic [7:0] held_byte  = 8'h00;
    bit         held_valid = 1'b0;
    always @(negedge masterClock) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && txValid) check("tx_hold", txByte, held_byte);
            held_valid = 1'b0;
            if (txValid && txReady) begin
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", txByte);
                end else begin
                    check("tx_byte", txByte, tx_q.pop_front());
                end
            end else if (txValid) begin
                held_byte  = txByte;
                held_valid = 1'b1;
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge masterClock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxValid = 1'b1;
        rxByte  = b;
        @(posedge masterClock);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
        send_byte(c);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    task automatic drain_tx();
        for (int i = 0; i < 100 && tx_q.size() != 0; i++) idle(1);
        check("tx_drain", 64'(tx_q.size()), 64'd0);
    endtask

    task automatic push_tx(input logic [7:0] s, input logic [31:0] d);
        tx_q.push_back(s);
        tx_q.push_back(d[31:24]);
        tx_q.push_back(d[23:16]);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
    endtask

    // Pop the expected frame and compare against the held outputs.
    task automatic check_frame(input string tag);
        logic [39:0] exp;
        exp = rx_q.pop_front();
        check({tag, "_dr"},   dataReceived, 1'b1);
        check({tag, "_ctl"},  control,      exp[39:32]);
        check({tag, "_data"}, inputData,    exp[31:0]);
    endtask

    task automatic release_frame(input string tag);
        clearDR = 1'b1;
        idle(1);
        check({tag, "_dr_drop"}, dataReceived, 1'b0);
        clearDR = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit exp_ovr;
        exp_ovr = 1'b0;

        vecs[0] = '{ctl: 8'h01, data: 32'hDEADBEEF, clr_early: 1'b0, extra: 1'b0};
        vecs[1] = '{ctl: 8'h7E, data: 32'h00FF00FF, clr_early: 1'b1, extra: 1'b0};
        vecs[2] = '{ctl: 8'hFF, data: 32'hA5A55A5A, clr_early: 1'b1, extra: 1'b1};
        vecs[3] = '{ctl: 8'h80, data: 32'h12345678, clr_early: 1'b0, extra: 1'b1};

        // ---- reset with transmitData already high ----
        idle(3);
        check("rst_dr",   dataReceived, 1'b0);
        check("rst_ctl",  control,      8'h00);
        check("rst_data", inputData,    32'h0);
        check("rst_txv",  txValid,      1'b0);
        check("rst_txb",  txByte,       8'h00);
        check("rst_ovr",  rxOverrun,    1'b0);
        check("rst_to",   rxTimeout,    1'b0);
        reset = 1'b0;
        idle(4);
        check("no_edge_at_release", txValid, 1'b0);
        transmitData = 1'b0;

        // ---- table-driven receive frames ----
        for (int v = 0; v < 4; v++) begin
            rx_q.push_back({vecs[v].ctl, vecs[v].data});
            clearDR = vecs[v].clr_early;
            send_frame(vecs[v].ctl, vecs[v].data);
            if (vecs[v].clr_early) begin
                check("pend_dr", dataReceived, 1'b0);
                if (vecs[v].extra) begin
                    send_byte(8'h55);
                    exp_ovr = 1'b1;
                end
                clearDR = 1'b0;
                idle(1);
            end else if (vecs[v].extra) begin
                send_byte(8'h55);
                exp_ovr = 1'b1;
            end
            check_frame("vec");
            check("vec_ovr", rxOverrun, exp_ovr);
            release_frame("vec");
        end

        // ---- byte arriving exactly on the timeout cycle is accepted ----
        rx_q.push_back({8'h3C, 32'hCAFEF00D});
        send_byte(8'h3C);
        idle(TO - 1); send_byte(8'hCA);
        idle(TO - 1); send_byte(8'hFE);
        idle(TO - 1); send_byte(8'hF0);
        idle(TO - 1); send_byte(8'h0D);
        check("coincide_to", rxTimeout, 1'b0);
        check_frame("coincide");
        release_frame("coincide");

        // ---- timeout after a partial frame ----
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        idle(TO - 1);
        check("to_not_yet", rxTimeout, 1'b0);
        idle(1);
        check("to_set", rxTimeout, 1'b1);
        idle(4);
        check("to_no_dr", dataReceived, 1'b0);
        rx_q.push_back({8'h5A, 32'h0BADC0DE});
        send_frame(8'h5A, 32'h0BADC0DE);
        check_frame("after_to");
        release_frame("after_to");

        // ---- transmit with toggling txReady; inputs change mid-send ----
        status     = 8'hA5;
        outputData = 32'h12345678;
        push_tx(8'hA5, 32'h12345678);
        rdy_mode     = 1;
        transmitData = 1'b1;
        idle(2);
        status     = 8'hFF;
        outputData = 32'h00000000;
        drain_tx();
        idle(2);
        check("tx1_done", txValid, 1'b0);
        transmitData = 1'b0;
        idle(2);

        // ---- second edge mid-send is ignored ----
        rdy_mode     = 0;
        status       = 8'hC3;
        outputData   = 32'h9ABCDEF0;
        push_tx(8'hC3, 32'h9ABCDEF0);
        transmitData = 1'b1;
        idle(2);
        transmitData = 1'b0;
        idle(1);
        transmitData = 1'b1;
        drain_tx();
        idle(4);
        check("tx2_done", txValid, 1'b0);
        transmitData = 1'b0;
        idle(2);

        // ---- reset in the middle of transmit and receive frames ----
        rdy_mode     = 1;
        status       = 8'h3E;
        outputData   = 32'h01020304;
        push_tx(8'h3E, 32'h01020304);
        transmitData = 1'b1;
        idle(2);
        send_byte(8'h44);
        send_byte(8'h45);
        reset = 1'b1;
        tx_q.delete();
        idle(1);
        check("rst_mid_txv", txValid,   1'b0);
        check("rst_mid_txb", txByte,    8'h00);
        check("rst_mid_ovr", rxOverrun, 1'b0);
        check("rst_mid_to",  rxTimeout, 1'b0);
        check("rst_mid_ctl", control,   8'h00);
        reset = 1'b0;
        rdy_mode = 0;
        idle(6);
        check("rst_mid_quiet", txValid, 1'b0);
        rx_q.push_back({8'h77, 32'h89ABCDEF});
        send_frame(8'h77, 32'h89ABCDEF);
        check_frame("after_rst");
        release_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
